cell_comm_pkt_mux: RTL and testbench

CELL_COMM_PKT_MUX -- requirements
Module: cell_comm_pkt_mux

---
 rtl/cell_comm_pkg.sv | 6 +
 rtl/cell_comm_pkt_fifo.sv | 64 ++++++
 rtl/cell_comm_pkt_mux.sv | 106 ++++++++++
 tb/tb_cell_comm_pkt_mux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_comm_pkg.sv
// cell_comm_pkg: shared arbiter state type and sizing constants for the cell packet mux
package cell_comm_pkg;
  localparam int MAX_NUM_INPUTS = 8;
  localparam int TID_WIDTH = 3;
  typedef enum logic {IDLE, SEND} arb_state_t;
endpackage

// File: rtl/cell_comm_pkt_fifo.sv
// cell_comm_pkt_fifo: store-and-forward packet FIFO that discards packets hitting a full buffer; drop pulse exported with CELL_COMM_PKT_MUX_STATS_EN
module cell_comm_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  pkt_avail
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  , output logic                drop
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, pkt_start, pkt_cnt;
  logic dropping, commit_q, full, drop_hit, pop_last;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign drop_hit = wr_valid && !dropping && full && !rd_en;
  assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];
  assign pop_last = rd_en && rd_last;
  assign pkt_avail = pkt_cnt != '0;
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  assign drop = drop_hit;
`endif
  // Write side: append beats, rewind and swallow the rest of a packet on overflow, commit one cycle after TLAST
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      pkt_start <= '0;
      dropping <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (wr_valid && dropping) dropping <= !wr_last;
      else if (drop_hit) begin
        wr_ptr <= pkt_start;
        dropping <= !wr_last;
      end else if (wr_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_last) begin
          pkt_start <= wr_ptr + 1'b1;
          commit_q <= 1'b1;
        end
      end
    end
  // Beat storage, no reset needed since pointers define validity
  always_ff @(posedge clk)
    if (wr_valid && !dropping && !drop_hit) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  // Read side: advance head and track committed whole packets
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_ptr <= '0;
      pkt_cnt <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      pkt_cnt <= pkt_cnt + (AW+1)'(commit_q) - (AW+1)'(pop_last);
    end
endmodule

// File: rtl/cell_comm_pkt_mux.sv
// cell_comm_pkt_mux: round-robin store-and-forward AXI-Stream packet mux; dropCount stats with CELL_COMM_PKT_MUX_STATS_EN
module cell_comm_pkt_mux
  import cell_comm_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                             axisUserClk,
  input  logic                             axisUserResetN,
  input  logic [NUM_INPUTS-1:0]            sAxisTvalid,
  input  logic [NUM_INPUTS-1:0]            sAxisTlast,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] sAxisTdata,
  output logic [NUM_INPUTS-1:0]            sAxisTready,
  input  logic [NUM_INPUTS-1:0]            sArbSuppress,
  output logic                             mAxisTvalid,
  output logic                             mAxisTlast,
  output logic [DATA_WIDTH-1:0]            mAxisTdata,
  input  logic                             mAxisTready,
  output logic [TID_WIDTH-1:0]             mAxisTid
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  , output logic [NUM_INPUTS*16-1:0]       dropCount
`endif
);
  logic [NUM_INPUTS-1:0] avail, rd_en;
  logic [MAX_NUM_INPUTS-1:0] elig, last_v;
  logic [DATA_WIDTH-1:0] head [MAX_NUM_INPUTS];
  arb_state_t state, state_n;
  logic [TID_WIDTH-1:0] grant, grant_n, last_grant, last_grant_n, pick, j;
  logic found, done, take;
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  logic [NUM_INPUTS-1:0] drop;
`endif
  if (NUM_INPUTS < 1 || NUM_INPUTS > MAX_NUM_INPUTS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("cell_comm_pkt_mux: illegal NUM_INPUTS or FIFO_DEPTH");
  end
  assign sAxisTready = {NUM_INPUTS{axisUserResetN}};
  assign mAxisTvalid = state == SEND;
  assign mAxisTdata = mAxisTvalid ? head[grant] : '0;
  assign mAxisTlast = mAxisTvalid && last_v[grant];
  assign mAxisTid = grant;
  assign done = mAxisTvalid && mAxisTready && mAxisTlast;
  genvar i;
  for (i = 0; i < MAX_NUM_INPUTS; i++) begin : g_in
    if (i < NUM_INPUTS) begin : g_fifo
      assign rd_en[i] = mAxisTvalid && mAxisTready && grant == TID_WIDTH'(i);
      assign elig[i] = avail[i] && !sArbSuppress[i];
      cell_comm_pkt_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(axisUserClk),
        .rst_n(axisUserResetN),
        .wr_valid(sAxisTvalid[i] && sAxisTready[i]),
        .wr_last(sAxisTlast[i]),
        .wr_data(sAxisTdata[i*DATA_WIDTH +: DATA_WIDTH]),
        .rd_en(rd_en[i]),
        .rd_data(head[i]),
        .rd_last(last_v[i]),
        .pkt_avail(avail[i])
`ifdef CELL_COMM_PKT_MUX_STATS_EN
        , .drop(drop[i])
`endif
      );
    end else begin : g_pad
      assign elig[i] = 1'b0;
      assign last_v[i] = 1'b0;
      assign head[i] = '0;
    end
  end
  // Round-robin pick from last grant + 1, then IDLE/SEND next-state holding the grant until TLAST leaves
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    j = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      j = TID_WIDTH'((int'(last_grant) + k) % NUM_INPUTS);
      if (elig[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
    take = state == IDLE && found;
    state_n = take ? SEND : (state == SEND && done) ? IDLE : state;
    grant_n = take ? pick : grant;
    last_grant_n = take ? pick : last_grant;
  end
  // Arbiter state and grant registers
  always_ff @(posedge axisUserClk)
    if (!axisUserResetN) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= TID_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_grant_n;
    end
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  for (i = 0; i < NUM_INPUTS; i++) begin : g_stat
    logic [15:0] cnt;
    // Saturating dropped-packet counter for this input
    always_ff @(posedge axisUserClk)
      if (!axisUserResetN) cnt <= '0;
      else if (drop[i] && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
    assign dropCount[i*16 +: 16] = cnt;
  end
`endif
endmodule

// File: tb/tb_cell_comm_pkt_mux.sv
// tb_cell_comm_pkt_mux: directed self-checking bench for cell_comm_pkt_mux
module tb_cell_comm_pkt_mux;
  localparam int N = 4;
  localparam int W = 32;
  typedef struct packed {
    logic [2:0]  tid;
    logic        last;
    logic [31:0] data;
    logic [31:0] cyc;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] s_valid = '0, s_last = '0, supp = '0, s_ready;
  logic [N*W-1:0] s_data = '0;
  logic m_valid, m_last, m_ready = 1'b1;
  logic [W-1:0] m_data;
  logic [2:0] m_tid;
  logic [31:0] cyc = '0;
  logic [31:0] tl;
  int n_pass = 0;
  int n_total = 0;
  beat_t q[$];
`ifdef CELL_COMM_PKT_MUX_STATS_EN
  logic [N*16-1:0] drop_count;
`endif

  cell_comm_pkt_mux #(.NUM_INPUTS(N), .DATA_WIDTH(W), .FIFO_DEPTH(32)) dut (
    .axisUserClk(clk),
    .axisUserResetN(rst_n),
    .sAxisTvalid(s_valid),
    .sAxisTlast(s_last),
    .sAxisTdata(s_data),
    .sAxisTready(s_ready),
    .sArbSuppress(supp),
    .mAxisTvalid(m_valid),
    .mAxisTlast(m_last),
    .mAxisTdata(m_data),
    .mAxisTready(m_ready),
    .mAxisTid(m_tid)
`ifdef CELL_COMM_PKT_MUX_STATS_EN
    , .dropCount(drop_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && m_valid && m_ready) q.push_back('{m_tid, m_last, m_data, cyc});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    supp = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input int i, input logic [31:0] base, input int len, output logic [31:0] tl_cyc);
    tl_cyc = '0;
    for (int n = 0; n < len; n++) begin
      @(posedge clk);
      #1;
      s_valid[i] = 1'b1;
      s_data[i*W +: W] = base + n;
      s_last[i] = (n == len - 1);
      if (n == len - 1) tl_cyc = cyc;
    end
    @(posedge clk);
    #1;
    s_valid[i] = 1'b0;
    s_last[i] = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int b = 0;
    while (q.size() < n && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = '1;
    s_last = '1;
    s_data = '1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", m_last); else n_pass++;
    n_total++; if (m_data !== 32'h0) $display("FAIL reset_data: got %h want 0", m_data); else n_pass++;
    n_total++; if (m_tid !== 3'd0) $display("FAIL reset_tid: got %0d want 0", m_tid); else n_pass++;
    n_total++; if (s_ready !== 4'h0) $display("FAIL reset_sready: got %h want 0", s_ready); else n_pass++;
    s_valid = '0;
    s_last = '0;
    rst_n = 1'b1;
    #1;
    n_total++; if (s_ready !== 4'hF) $display("FAIL run_sready: got %h want f", s_ready); else n_pass++;
    idle(5);
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_nothing_stored: got valid %b want 0", m_valid); else n_pass++;
`ifdef CELL_COMM_PKT_MUX_STATS_EN
    n_total++; if (drop_count !== 64'h0) $display("FAIL reset_dropcount: got %h want 0", drop_count); else n_pass++;
`endif
  endtask

  task automatic test_single();
    do_reset();
    drive_pkt(2, 32'h11, 4, tl);
    wait_q(4);
    n_total++; if (q.size() != 4) $display("FAIL single_count: got %0d want 4", q.size()); else n_pass++;
    if (q.size() >= 4)
      for (int n = 0; n < 4; n++) begin
        n_total++; if (q[n].data !== 32'h11 + n) $display("FAIL single_data[%0d]: got %h want %h", n, q[n].data, 32'h11 + n); else n_pass++;
        n_total++; if (q[n].tid !== 3'd2) $display("FAIL single_tid[%0d]: got %0d want 2", n, q[n].tid); else n_pass++;
        n_total++; if (q[n].last !== (n == 3)) $display("FAIL single_last[%0d]: got %b want %b", n, q[n].last, n == 3); else n_pass++;
        n_total++; if (q[n].cyc !== tl + 3 + n) $display("FAIL single_timing[%0d]: got cycle %0d want %0d", n, q[n].cyc, tl + 3 + n); else n_pass++;
      end
  endtask

  task automatic test_arbitration();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      s_valid = '1;
      s_last = (n == 2) ? 4'hF : 4'h0;
      for (int i = 0; i < N; i++) s_data[i*W +: W] = 32'((i + 1) * 16 + n);
    end
    @(posedge clk);
    #1;
    s_valid = '0;
    s_last = '0;
    wait_q(12);
    idle(5);
    n_total++; if (q.size() != 12) $display("FAIL arb_count: got %0d want 12", q.size()); else n_pass++;
    if (q.size() >= 12)
      for (int p = 0; p < 4; p++)
        for (int n = 0; n < 3; n++) begin
          n_total++; if (q[p*3+n].tid !== 3'(p)) $display("FAIL arb_tid[%0d]: got %0d want %0d", p*3+n, q[p*3+n].tid, p); else n_pass++;
          n_total++; if (q[p*3+n].data !== 32'((p + 1) * 16 + n)) $display("FAIL arb_data[%0d]: got %h want %h", p*3+n, q[p*3+n].data, (p + 1) * 16 + n); else n_pass++;
          n_total++; if (q[p*3+n].last !== (n == 2)) $display("FAIL arb_last[%0d]: got %b want %b", p*3+n, q[p*3+n].last, n == 2); else n_pass++;
          if (n > 0) begin
            n_total++; if (q[p*3+n].cyc - q[p*3+n-1].cyc !== 32'd1) $display("FAIL arb_burst[%0d]: got gap %0d want 1", p*3+n, q[p*3+n].cyc - q[p*3+n-1].cyc); else n_pass++;
          end else if (p > 0) begin
            n_total++; if (q[p*3].cyc - q[p*3-1].cyc > 32'd2) $display("FAIL arb_gap[%0d]: got gap %0d want <=2", p, q[p*3].cyc - q[p*3-1].cyc); else n_pass++;
          end
        end
  endtask

  task automatic test_drop();
    do_reset();
    drive_pkt(1, 32'h100, 40, tl);
    idle(10);
    n_total++; if (q.size() != 0) $display("FAIL drop_no_output: got %0d beats want 0", q.size()); else n_pass++;
`ifdef CELL_COMM_PKT_MUX_STATS_EN
    n_total++; if (drop_count !== 64'h0000_0000_0001_0000) $display("FAIL drop_count: got %h want 0000000000010000", drop_count); else n_pass++;
`endif
    drive_pkt(1, 32'h51, 4, tl);
    wait_q(4);
    idle(5);
    n_total++; if (q.size() != 4) $display("FAIL drop_next_count: got %0d want 4", q.size()); else n_pass++;
    if (q.size() >= 4)
      for (int n = 0; n < 4; n++) begin
        n_total++; if (q[n].data !== 32'h51 + n || q[n].tid !== 3'd1 || q[n].last !== (n == 3)) $display("FAIL drop_next_beat[%0d]: got tid %0d data %h last %b want tid 1 data %h last %b", n, q[n].tid, q[n].data, q[n].last, 32'h51 + n, n == 3); else n_pass++;
      end
  endtask

  task automatic test_stall();
    int b = 0;
    do_reset();
    m_ready = 1'b0;
    drive_pkt(3, 32'hA1, 4, tl);
    while (!m_valid && b < 50) begin
      @(posedge clk);
      #1;
      b++;
    end
    n_total++; if (m_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", m_valid); else n_pass++;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    n_total++; if (m_data !== 32'hA2 || m_tid !== 3'd3 || m_valid !== 1'b1) $display("FAIL stall_hold1: got data %h tid %0d valid %b want a2 3 1", m_data, m_tid, m_valid); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (m_data !== 32'hA2 || m_tid !== 3'd3 || m_valid !== 1'b1 || m_last !== 1'b0) $display("FAIL stall_hold2: got data %h tid %0d valid %b last %b want a2 3 1 0", m_data, m_tid, m_valid, m_last); else n_pass++;
    m_ready = 1'b1;
    wait_q(4);
    idle(5);
    n_total++; if (q.size() != 4) $display("FAIL stall_count: got %0d want 4", q.size()); else n_pass++;
    if (q.size() >= 4)
      for (int n = 0; n < 4; n++) begin
        n_total++; if (q[n].data !== 32'hA1 + n || q[n].tid !== 3'd3 || q[n].last !== (n == 3)) $display("FAIL stall_beat[%0d]: got tid %0d data %h last %b want tid 3 data %h last %b", n, q[n].tid, q[n].data, q[n].last, 32'hA1 + n, n == 3); else n_pass++;
      end
  endtask

  task automatic test_suppress();
    do_reset();
    supp = 4'b0001;
    drive_pkt(0, 32'h61, 2, tl);
    drive_pkt(1, 32'h71, 2, tl);
    wait_q(2);
    idle(10);
    n_total++; if (q.size() != 2) $display("FAIL supp_count: got %0d want 2", q.size()); else n_pass++;
    if (q.size() >= 2)
      for (int n = 0; n < 2; n++) begin
        n_total++; if (q[n].tid !== 3'd1 || q[n].data !== 32'h71 + n) $display("FAIL supp_beat[%0d]: got tid %0d data %h want tid 1 data %h", n, q[n].tid, q[n].data, 32'h71 + n); else n_pass++;
      end
    q.delete();
    supp = 4'b0000;
    wait_q(2);
    idle(5);
    n_total++; if (q.size() != 2) $display("FAIL release_count: got %0d want 2", q.size()); else n_pass++;
    if (q.size() >= 2)
      for (int n = 0; n < 2; n++) begin
        n_total++; if (q[n].tid !== 3'd0 || q[n].data !== 32'h61 + n || q[n].last !== (n == 1)) $display("FAIL release_beat[%0d]: got tid %0d data %h last %b want tid 0 data %h last %b", n, q[n].tid, q[n].data, q[n].last, 32'h61 + n, n == 1); else n_pass++;
      end
  endtask

  task automatic test_reset_mid();
    int b = 0;
    do_reset();
    drive_pkt(2, 32'h81, 5, tl);
    while (!m_valid && b < 50) begin
      @(posedge clk);
      #1;
      b++;
    end
    @(posedge clk);
    #1;
    n_total++; if (m_data !== 32'h82) $display("FAIL rmid_beat2: got %h want 82", m_data); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 || m_tid !== 3'd0 || s_ready !== 4'h0) $display("FAIL rmid_outputs: got valid %b last %b data %h tid %0d sready %h want 0 0 0 0 0", m_valid, m_last, m_data, m_tid, s_ready); else n_pass++;
    rst_n = 1'b1;
    q.delete();
    drive_pkt(0, 32'h91, 3, tl);
    wait_q(3);
    idle(10);
    n_total++; if (q.size() != 3) $display("FAIL rmid_fresh_count: got %0d want 3", q.size()); else n_pass++;
    if (q.size() >= 3)
      for (int n = 0; n < 3; n++) begin
        n_total++; if (q[n].tid !== 3'd0 || q[n].data !== 32'h91 + n || q[n].last !== (n == 2)) $display("FAIL rmid_fresh_beat[%0d]: got tid %0d data %h last %b want tid 0 data %h last %b", n, q[n].tid, q[n].data, q[n].last, 32'h91 + n, n == 2); else n_pass++;
      end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_drop();
    test_stall();
    test_suppress();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
